// File: rtl/cpu_io_pkg.sv
// Shared definitions for the CPU I/O port blocks: port address default,
// serial frame geometry and the transmitter state encoding.
package cpu_io_pkg;

  localparam logic [7:0] IO_ADDR_DEFAULT = 8'hFF;

  // 8N1 frame: start + 8 data + stop.
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = FRAME_BITS - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/baud_tick.sv
// Free-running bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the
// last cycle of each bit. Held at zero while clr is asserted.
module baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic nclear,
  input  logic clr,
  output logic tick_out
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state always uses non-blocking (<=) so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clock or negedge nclear) begin
    if (!nclear) begin
      count <= '0;
    end else if (clr || tick_out) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick_out = (count == LAST);

endmodule

// File: rtl/serial_tx_port.sv
// Memory-mapped 8N1 serial transmitter for the CPU's I/O address, with a
// one-byte holding buffer so a second store can be queued mid-frame.
module serial_tx_port
  import cpu_io_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] IO_ADDR      = IO_ADDR_DEFAULT
) (
  input  logic       clock,
  input  logic       nclear,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  input  logic       we,
  output logic       serial_out,
  output logic       busy,
  output logic       hold_full,
  output logic       overrun,
  output logic       tx_done
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t  state, state_next;
  logic [7:0] shift;
  logic [7:0] hold;
  logic [2:0] bit_idx;
  logic       bit_end;
  logic       wr;

  assign wr = we && (addr == IO_ADDR);

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock    (clock),
    .nclear   (nclear),
    .clr      (state == IDLE),
    .tick_out (bit_end)
  );

  always_ff @(posedge clock or negedge nclear) begin
    if (!nclear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (wr) state_next = START;
      START: if (bit_end) state_next = DATA;
      DATA:  if (bit_end && bit_idx == LAST_BIT) state_next = STOP;
      STOP:  if (bit_end) state_next = (hold_full || wr) ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    serial_out = 1'b1;
    tx_done    = 1'b0;
    busy       = (state != IDLE) || hold_full;
    case (state)
      START:   serial_out = 1'b0;
      DATA:    serial_out = shift[0];
      STOP:    tx_done    = bit_end;
      default: ;
    endcase
  end

  // Shift register, bit index, holding buffer and sticky overrun.
  always_ff @(posedge clock or negedge nclear) begin
    if (!nclear) begin
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      overrun   <= 1'b0;
      bit_idx   <= '0;
    end else begin
      case (state)
        IDLE:  if (wr) shift <= din;
        START: if (bit_end) bit_idx <= '0;
        DATA: begin
          if (bit_end) begin
            shift <= {1'b0, shift[7:1]};
            if (bit_idx != LAST_BIT) bit_idx <= bit_idx + 1'b1;
          end
        end
        default: ;
      endcase

      // At the stop-bit boundary the buffered byte (or a coincident store)
      // feeds the next frame directly, so a store here is never an overrun.
      if (state == STOP && bit_end) begin
        if (hold_full) begin
          shift <= hold;
          if (wr) hold <= din;
          else    hold_full <= 1'b0;
        end else if (wr) begin
          shift <= din;
        end
      end else if (wr && state != IDLE) begin
        if (!hold_full) begin
          hold      <= din;
          hold_full <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_tx_port.sv
// Self-checking bench for serial_tx_port: a line monitor decodes frames and
// compares them against a queue of expected bytes; tasks check timing/flags.
module tb_serial_tx_port;
  import cpu_io_pkg::*;

  localparam int CPB = 4;

  logic       clock = 1'b0;
  logic       nclear;
  logic [7:0] addr;
  logic [7:0] din;
  logic       we;
  logic       serial_out;
  logic       busy;
  logic       hold_full;
  logic       overrun;
  logic       tx_done;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  bit         monitor_en = 1'b1;

  serial_tx_port #(
    .CLKS_PER_BIT(CPB),
    .IO_ADDR     (8'hFF)
  ) dut (
    .clock      (clock),
    .nclear     (nclear),
    .addr       (addr),
    .din        (din),
    .we         (we),
    .serial_out (serial_out),
    .busy       (busy),
    .hold_full  (hold_full),
    .overrun    (overrun),
    .tx_done    (tx_done)
  );

  always #5 clock = ~clock;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Line monitor: sample each bit mid-period, pop expected byte at the stop bit.
  initial begin : monitor
    logic [7:0] got;
    logic [7:0] want;
    forever begin
      @(negedge clock);
      if (monitor_en && nclear === 1'b1 && serial_out === 1'b0) begin
        repeat (CPB / 2) @(negedge clock);
        checks++;
        if (serial_out !== 1'b0) begin
          failures++;
          $display("FAIL mon_start_bit: serial_out=%b expected 0", serial_out);
        end
        for (int b = 0; b < DATA_BITS; b++) begin
          repeat (CPB) @(negedge clock);
          got[b] = serial_out;
        end
        repeat (CPB) @(negedge clock);
        checks++;
        if (serial_out !== 1'b1) begin
          failures++;
          $display("FAIL mon_stop_bit: serial_out=%b expected 1", serial_out);
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL mon_unexpected_frame: got=%h expected no frame", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            failures++;
            $display("FAIL mon_frame_byte: got=%h expected %h", got, want);
          end
        end
      end
    end
  end

  task automatic drive_write(input logic [7:0] a, input logic [7:0] d, input bit push);
    @(negedge clock);
    addr = a;
    din  = d;
    we   = 1'b1;
    if (push) exp_q.push_back(d);
  endtask

  task automatic release_bus();
    @(negedge clock);
    we   = 1'b0;
    addr = 8'h00;
  endtask

  task automatic wait_tx_done(input int max_cycles, input string name);
    bit found = 1'b0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      @(negedge clock);
      if (tx_done === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s: tx_done not seen within %0d cycles", name, max_cycles);
    end
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    bit idle = 1'b0;
    for (int i = 0; i < max_cycles && !idle; i++) begin
      @(negedge clock);
      if (busy === 1'b0) idle = 1'b1;
    end
    checks++;
    if (!idle) begin
      failures++;
      $display("FAIL %s: busy still %b after %0d cycles", name, busy, max_cycles);
    end
    repeat (4) @(negedge clock);
  endtask

  task automatic check_flags(input string name, input logic [4:0] expected);
    logic [4:0] observed;
    observed = {serial_out, busy, hold_full, overrun, tx_done};
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: {serial_out,busy,hold_full,overrun,tx_done}=%b expected %b",
               name, observed, expected);
    end
  endtask

  task automatic test_reset();
    nclear = 1'b0;
    we     = 1'b0;
    addr   = 8'h00;
    din    = 8'h00;
    repeat (3) @(negedge clock);
    check_flags("reset_held", 5'b10000);
    nclear = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      check_flags("reset_idle", 5'b10000);
    end
  endtask

  task automatic test_single_frame();
    logic [FRAME_BITS-1:0] frame;
    frame = {1'b1, 8'hA5, 1'b0};
    drive_write(8'hFF, 8'hA5, 1'b1);
    release_bus();
    for (int i = 0; i < FRAME_BITS * CPB; i++) begin
      checks++;
      if (serial_out !== frame[i / CPB] || busy !== 1'b1) begin
        failures++;
        $display("FAIL single_line cycle %0d: serial_out=%b busy=%b expected %b/1",
                 i + 1, serial_out, busy, frame[i / CPB]);
      end
      checks++;
      if (tx_done !== (i == FRAME_BITS * CPB - 1)) begin
        failures++;
        $display("FAIL single_tx_done cycle %0d: tx_done=%b expected %b",
                 i + 1, tx_done, (i == FRAME_BITS * CPB - 1));
      end
      @(negedge clock);
    end
    check_flags("single_after_frame", 5'b10000);
    repeat (4) @(negedge clock);
  endtask

  task automatic test_hold_buffer();
    drive_write(8'hFF, 8'h3C, 1'b1);
    release_bus();
    repeat (14) @(negedge clock);
    drive_write(8'hFF, 8'hC3, 1'b1);
    release_bus();
    check_flags("hold_after_second_write", {serial_out, 4'b1100});
    wait_tx_done(60, "hold_first_done");
    @(negedge clock);
    check_flags("hold_no_gap_start", 5'b01000);
    wait_idle(80, "hold_drain");
  endtask

  task automatic test_stop_collision();
    drive_write(8'hFF, 8'h5A, 1'b1);
    release_bus();
    wait_tx_done(60, "collision_first_done");
    check_flags("collision_at_stop_end", 5'b11001);
    addr = 8'hFF;
    din  = 8'h96;
    we   = 1'b1;
    exp_q.push_back(8'h96);
    @(negedge clock);
    we   = 1'b0;
    addr = 8'h00;
    check_flags("collision_next_start", 5'b01000);
    wait_idle(80, "collision_drain");
  endtask

  task automatic test_wrong_addr();
    drive_write(8'hFE, 8'h99, 1'b0);
    @(negedge clock);
    addr = 8'hFF;
    we   = 1'b0;
    release_bus();
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check_flags("wrong_addr_idle", 5'b10000);
    end
  endtask

  task automatic test_back_to_back_overrun();
    check_flags("overrun_before", 5'b10000);
    drive_write(8'hFF, 8'h11, 1'b1);
    drive_write(8'hFF, 8'h22, 1'b1);
    drive_write(8'hFF, 8'h33, 1'b0);
    release_bus();
    check_flags("overrun_set", 5'b01110);
    wait_idle(150, "overrun_drain");
    check_flags("overrun_sticky", 5'b10010);
  endtask

  task automatic test_reset_mid_frame();
    monitor_en = 1'b0;
    drive_write(8'hFF, 8'h77, 1'b0);
    release_bus();
    repeat (8) @(negedge clock);
    drive_write(8'hFF, 8'hEE, 1'b0);
    release_bus();
    repeat (6) @(negedge clock);
    #2 nclear = 1'b0;
    #1 check_flags("reset_mid_async", 5'b10000);
    @(negedge clock);
    nclear = 1'b1;
    repeat (2) @(negedge clock);
    check_flags("reset_mid_released", 5'b10000);
    monitor_en = 1'b1;
    drive_write(8'hFF, 8'h4B, 1'b1);
    release_bus();
    check_flags("reset_mid_new_start", 5'b01000);
    wait_idle(80, "reset_mid_drain");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_hold_buffer();
    test_stop_collision();
    test_wrong_addr();
    test_back_to_back_overrun();
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drained: %0d bytes never seen, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
